// File: rtl/regfile_writeback_arbiter_if.sv
// Write-port bundle between the core/multi-cycle unit (master) and the
// register-file writeback arbiter (slave).
interface regfile_writeback_arbiter_if #(
   parameter int unsigned DEPTH = 4
);
   logic                         pipe_valid_i;
   logic [4:0]                   pipe_rd_i;
   logic [31:0]                  pipe_data_i;
   logic                         mc_valid_i;
   logic                         mc_ready_o;
   logic [4:0]                   mc_rd_i;
   logic [31:0]                  mc_data_i;
   logic                         pipe_stall_o;
   logic [4:0]                   rs1_i;
   logic [4:0]                   rs2_i;
   logic                         hazard_rs1_o;
   logic                         hazard_rs2_o;
   logic                         reg_write_o;
   logic [4:0]                   write_register_o;
   logic [31:0]                  write_data_o;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count_o;

   modport master (
      output pipe_valid_i, pipe_rd_i, pipe_data_i, mc_valid_i, mc_rd_i, mc_data_i, rs1_i, rs2_i,
      input  mc_ready_o, pipe_stall_o, hazard_rs1_o, hazard_rs2_o, reg_write_o,
             write_register_o, write_data_o, fifo_count_o
   );

   modport slave (
      input  pipe_valid_i, pipe_rd_i, pipe_data_i, mc_valid_i, mc_rd_i, mc_data_i, rs1_i, rs2_i,
      output mc_ready_o, pipe_stall_o, hazard_rs1_o, hazard_rs2_o, reg_write_o,
             write_register_o, write_data_o, fifo_count_o
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline writeback (priority) and buffered multi-cycle results onto the single
// register-file write port. Define WB_BYPASS_EN for zero-latency mc writes into an idle port.
module regfile_writeback_arbiter #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic                        clk,
   input logic                        rst,
   regfile_writeback_arbiter_if.slave wb
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    rd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [SW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;

   logic pipe_win, empty, ready, accept_nz, pop, push, bypass;
   logic haz1, haz2;

   always_comb begin
      pipe_win  = wb.pipe_valid_i & ~stall_q & (wb.pipe_rd_i != 5'd0);
      empty     = (count_q == '0);
      ready     = (count_q < CW'(DEPTH));
      accept_nz = wb.mc_valid_i & ready & (wb.mc_rd_i != 5'd0);
      pop       = ~pipe_win & ~empty;
`ifdef WB_BYPASS_EN
      bypass    = accept_nz & empty & ~pipe_win;
`else
      bypass    = 1'b0;
`endif
      push      = accept_nz & ~bypass;

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Counter saturates at the limit; stall holds until the buffered head drains.
      starve_d = starve_q;
      if (empty || pop) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end
      stall_d = pop ? 1'b0 : (stall_q | (starve_d == SW'(STARVE_LIMIT)));
   end

   // The head being popped is excluded: the register file write-through covers it.
   always_comb begin : hazard_scan
      logic [PW-1:0] off;
      logic          live;
      haz1 = 1'b0;
      haz2 = 1'b0;
      off  = '0;
      live = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off  = PW'(i) - rd_ptr_q;
         live = (CW'(off) < count_q) && !(pop && (off == '0));
         if (live && (rd_mem[i] == wb.rs1_i) && (wb.rs1_i != 5'd0)) haz1 = 1'b1;
         if (live && (rd_mem[i] == wb.rs2_i) && (wb.rs2_i != 5'd0)) haz2 = 1'b1;
      end
   end

   always_comb begin
      wb.reg_write_o      = 1'b0;
      wb.write_register_o = wb.pipe_rd_i;
      wb.write_data_o     = wb.pipe_data_i;
      if (pipe_win) begin
         wb.reg_write_o = 1'b1;
      end else if (pop) begin
         wb.reg_write_o      = 1'b1;
         wb.write_register_o = rd_mem[rd_ptr_q];
         wb.write_data_o     = data_mem[rd_ptr_q];
      end else if (bypass) begin
         wb.reg_write_o      = 1'b1;
         wb.write_register_o = wb.mc_rd_i;
         wb.write_data_o     = wb.mc_data_i;
      end
   end

   assign wb.mc_ready_o   = ready;
   assign wb.pipe_stall_o = stall_q;
   assign wb.hazard_rs1_o = haz1;
   assign wb.hazard_rs2_o = haz2;
   assign wb.fifo_count_o = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr_q]   <= wb.mc_rd_i;
         data_mem[wr_ptr_q] <= wb.mc_data_i;
      end
   end

`ifndef SYNTHESIS
   stall_blocks_pipe: assert property (@(posedge clk) disable iff (rst)
      stall_q |-> !wb.pipe_valid_i)
      else $error("pipe_valid_i high while pipe_stall_o is set");
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench: the driver queues each cycle's expected write, a monitor checks the
// write port every cycle; registered/status outputs are checked inline.
module tb_regfile_writeback_arbiter;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   wr_t  exp_q[$];

   always #5 clk = ~clk;

   regfile_writeback_arbiter_if #(.DEPTH(4)) wb ();

   regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus plus the write the cycle is expected to produce.
   task automatic cyc(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic ew, input logic [4:0] erd, input logic [31:0] ed);
      wr_t e;
      @(negedge clk);
      wb.pipe_valid_i = pv;
      wb.pipe_rd_i    = prd;
      wb.pipe_data_i  = pd;
      wb.mc_valid_i   = mv;
      wb.mc_rd_i      = mrd;
      wb.mc_data_i    = md;
      wb.rs1_i        = r1;
      wb.rs2_i        = r2;
      if (ew) begin
         e.rd   = erd;
         e.data = ed;
         exp_q.push_back(e);
      end
      #2;
   endtask

   initial begin : monitor
      wr_t e;
      forever begin
         @(negedge clk);
         #3;
         if (wb.reg_write_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(wb.reg_write_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", 32'(wb.write_register_o), 32'(e.rd));
               chk("write_data", wb.write_data_o, e.data);
            end
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_write", 32'(wb.reg_write_o), 32'd1);
         end
      end
   end

   initial begin : stimulus
      wb.pipe_valid_i = 1'b0;
      wb.pipe_rd_i    = '0;
      wb.pipe_data_i  = '0;
      wb.mc_valid_i   = 1'b0;
      wb.mc_rd_i      = '0;
      wb.mc_data_i    = '0;
      wb.rs1_i        = '0;
      wb.rs2_i        = '0;
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(wb.fifo_count_o), 32'd0);
      chk("rst_ready", 32'(wb.mc_ready_o), 32'd1);
      chk("rst_write", 32'(wb.reg_write_o), 32'd0);
      chk("rst_stall", 32'(wb.pipe_stall_o), 32'd0);
      chk("rst_haz", 32'(wb.hazard_rs1_o), 32'd0);
      rst = 1'b0;

      // 1: pipe write, zero latency
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
      chk("t1_we", 32'(wb.reg_write_o), 32'd1);
      chk("t1_addr", 32'(wb.write_register_o), 32'd5);
      chk("t1_data", wb.write_data_o, 32'hDEADBEEF);

      // 2: buffered result, hazard, drain when pipe idles
      cyc(1, 1, 32'h1, 1, 7, 32'h11, 0, 0, 1, 1, 32'h1);
      chk("t2_ready", 32'(wb.mc_ready_o), 32'd1);
      cyc(1, 1, 32'h2, 0, 0, 0, 7, 0, 1, 1, 32'h2);
      chk("t2_count", 32'(wb.fifo_count_o), 32'd1);
      chk("t2_haz1_on", 32'(wb.hazard_rs1_o), 32'd1);
      chk("t2_haz2_zero", 32'(wb.hazard_rs2_o), 32'd0);
      cyc(1, 1, 32'h3, 0, 0, 0, 0, 7, 1, 1, 32'h3);
      chk("t2_haz1_rs0", 32'(wb.hazard_rs1_o), 32'd0);
      chk("t2_haz2_on", 32'(wb.hazard_rs2_o), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 32'h11);
      chk("t2_haz_drop", 32'(wb.hazard_rs1_o), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_count_after", 32'(wb.fifo_count_o), 32'd0);

      // 3: fill to DEPTH, back-pressure, full+pop blocks push
      cyc(1, 2, 32'h201, 1, 10, 32'h100, 0, 0, 1, 2, 32'h201);
      cyc(1, 2, 32'h202, 1, 11, 32'h101, 0, 0, 1, 2, 32'h202);
      cyc(1, 2, 32'h203, 1, 12, 32'h102, 0, 0, 1, 2, 32'h203);
      cyc(1, 2, 32'h204, 1, 13, 32'h103, 0, 0, 1, 2, 32'h204);
      chk("t3_count3", 32'(wb.fifo_count_o), 32'd3);
      cyc(1, 2, 32'h205, 1, 14, 32'h104, 0, 0, 1, 2, 32'h205);
      chk("t3_full_ready", 32'(wb.mc_ready_o), 32'd0);
      chk("t3_full_count", 32'(wb.fifo_count_o), 32'd4);
      cyc(0, 0, 0, 1, 14, 32'h104, 0, 0, 1, 10, 32'h100);
      chk("t3_pop_ready", 32'(wb.mc_ready_o), 32'd0);
      cyc(1, 2, 32'h207, 1, 14, 32'h104, 14, 11, 1, 2, 32'h207);
      chk("t3_ready_back", 32'(wb.mc_ready_o), 32'd1);
      chk("t3_count_pop", 32'(wb.fifo_count_o), 32'd3);
      chk("t3_haz_new", 32'(wb.hazard_rs1_o), 32'd0);
      chk("t3_haz_old", 32'(wb.hazard_rs2_o), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'h101);
      chk("t3_count4", 32'(wb.fifo_count_o), 32'd4);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'h102);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'h103);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 32'h104);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_drained", 32'(wb.fifo_count_o), 32'd0);

      // 4: starvation stall after 8 denied cycles
      cyc(1, 2, 32'h300, 1, 9, 32'h99, 0, 0, 1, 2, 32'h300);
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 2, 32'h300 + 32'(i), 0, 0, 0, 0, 0, 1, 2, 32'h300 + 32'(i));
         chk("t4_no_stall", 32'(wb.pipe_stall_o), 32'd0);
      end
      cyc(0, 0, 0, 0, 0, 0, 9, 0, 1, 9, 32'h99);
      chk("t4_stall", 32'(wb.pipe_stall_o), 32'd1);
      chk("t4_haz_pop", 32'(wb.hazard_rs1_o), 32'd0);
      cyc(1, 2, 32'h30A, 0, 0, 0, 0, 0, 1, 2, 32'h30A);
      chk("t4_stall_low", 32'(wb.pipe_stall_o), 32'd0);
      chk("t4_count", 32'(wb.fifo_count_o), 32'd0);

      // 5: pipe rd=0 does not take the port
      cyc(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 0);
      cyc(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 1, 3, 32'h33);
      chk("t5_count1", 32'(wb.fifo_count_o), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_count0", 32'(wb.fifo_count_o), 32'd0);

      // 6: async reset with 3 entries buffered
      cyc(1, 4, 32'h401, 1, 20, 32'h500, 0, 0, 1, 4, 32'h401);
      cyc(1, 4, 32'h402, 1, 21, 32'h501, 0, 0, 1, 4, 32'h402);
      cyc(1, 4, 32'h403, 1, 22, 32'h502, 0, 0, 1, 4, 32'h403);
      @(negedge clk);
      wb.pipe_valid_i = 1'b0;
      wb.mc_valid_i   = 1'b0;
      wb.rs1_i        = 5'd20;
      chk("t6_count_pre", 32'(wb.fifo_count_o), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("t6_count", 32'(wb.fifo_count_o), 32'd0);
      chk("t6_ready", 32'(wb.mc_ready_o), 32'd1);
      chk("t6_write", 32'(wb.reg_write_o), 32'd0);
      chk("t6_haz", 32'(wb.hazard_rs1_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0);
      chk("t6_count_after", 32'(wb.fifo_count_o), 32'd0);

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
